// File: rtl/toggle_edge_counter.sv
// Counts toggle events from a falling-edge T flip-flop, modulo MOD, with wrap or saturate.
// Optional macro TOGGLE_SYNC_EN inserts a two-flop synchronizer ahead of the sampling pipeline.
module toggle_edge_counter #(
    parameter int unsigned MOD       = 10,
    parameter int unsigned W         = 4,
    parameter int unsigned EDGE_MODE = 0,
    parameter int unsigned WRAP      = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         t_in,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         event_o,
    output logic         tc,
    output logic         sat
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    logic         w_t_in_s;
    logic         r_t1;
    logic         r_t2;
    logic         w_ev;

    state_t       r_state;
    state_t       w_nxt_state;
    logic [W-1:0] r_count;
    logic [W-1:0] w_nxt_count;
    logic         r_event;
    logic         w_nxt_event;
    logic         r_tc;
    logic         w_nxt_tc;
    logic         r_sat;
    logic         w_nxt_sat;

`ifdef TOGGLE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for asynchronous toggle sources.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= t_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_t_in_s = r_sync2;
`else
    assign w_t_in_s = t_in;
`endif

    // Sampling pipeline; keeps running through clr so in-flight events are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_t1 <= 1'b0;
            r_t2 <= 1'b0;
        end else begin
            r_t1 <= w_t_in_s;
            r_t2 <= r_t1;
        end
    end

    generate
        if (EDGE_MODE == 0) begin : g_both_edges
            assign w_ev = r_t1 ^ r_t2;
        end else begin : g_rise_only
            assign w_ev = r_t1 & ~r_t2;
        end
    endgenerate

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_event <= 1'b0;
            r_tc    <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_count <= w_nxt_count;
            r_event <= w_nxt_event;
            r_tc    <= w_nxt_tc;
            r_sat   <= w_nxt_sat;
        end
    end

    // Next-state and next-output logic; clr overrides everything else.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_nxt_event = 1'b0;
        w_nxt_tc    = 1'b0;

        if (clr) begin
            w_nxt_count = '0;
            w_nxt_state = en ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        w_nxt_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        w_nxt_state = ST_IDLE;
                    end else if (w_ev) begin
                        w_nxt_event = 1'b1;
                        if (r_count == LAST) begin
                            w_nxt_tc = 1'b1;
                            if (WRAP != 0) begin
                                w_nxt_count = '0;
                            end else begin
                                w_nxt_state = ST_SAT;
                            end
                        end else begin
                            w_nxt_count = r_count + W'(1);
                        end
                    end
                end
                ST_SAT: begin
                    w_nxt_state = ST_SAT;
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_count = '0;
                end
            endcase
        end

        w_nxt_sat = (w_nxt_state == ST_SAT);
    end

    assign count   = r_count;
    assign event_o = r_event;
    assign tc      = r_tc;
    assign sat     = r_sat;

endmodule

// File: tb/tb_toggle_edge_counter.sv
// Directed bench for toggle_edge_counter: wrap, rising-edge-only and saturating variants share stimulus.
module tb_toggle_edge_counter;

    logic clock;
    logic reset_n;
    logic t_in;
    logic en;
    logic clr;

    logic [3:0] cnt_w, cnt_e, cnt_s;
    logic       ev_w, ev_e, ev_s;
    logic       tc_w, tc_e, tc_s;
    logic       sat_w, sat_e, sat_s;

    int n_checks;
    int n_pass;
    int ev_cnt_w, ev_cnt_e, ev_cnt_s;
    int tc_cnt_w, tc_cnt_s;

    toggle_edge_counter #(.MOD(10), .W(4), .EDGE_MODE(0), .WRAP(1)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .t_in(t_in), .en(en), .clr(clr),
        .count(cnt_w), .event_o(ev_w), .tc(tc_w), .sat(sat_w)
    );

    toggle_edge_counter #(.MOD(10), .W(4), .EDGE_MODE(1), .WRAP(1)) dut_edge (
        .clock(clock), .reset_n(reset_n), .t_in(t_in), .en(en), .clr(clr),
        .count(cnt_e), .event_o(ev_e), .tc(tc_e), .sat(sat_e)
    );

    toggle_edge_counter #(.MOD(10), .W(4), .EDGE_MODE(0), .WRAP(0)) dut_sat (
        .clock(clock), .reset_n(reset_n), .t_in(t_in), .en(en), .clr(clr),
        .count(cnt_s), .event_o(ev_s), .tc(tc_s), .sat(sat_s)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive inputs on the falling edge (as the T flip-flop would), sample 1 ns after the rising edge.
    task automatic tick(input bit tog, input bit c, input bit e);
        @(negedge clock);
        if (tog) t_in = ~t_in;
        clr = c;
        en  = e;
        @(posedge clock);
        #1;
        ev_cnt_w += int'(ev_w);
        ev_cnt_e += int'(ev_e);
        ev_cnt_s += int'(ev_s);
        tc_cnt_w += int'(tc_w);
        tc_cnt_s += int'(tc_s);
    endtask

    task automatic clear_tallies();
        ev_cnt_w = 0; ev_cnt_e = 0; ev_cnt_s = 0;
        tc_cnt_w = 0; tc_cnt_s = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        t_in    = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_count", int'(cnt_w), 0);
        check("rst_event", int'(ev_w), 0);
        check("rst_tc", int'(tc_w), 0);
        check("rst_sat", int'(sat_s), 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        t_in     = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        clear_tallies();

        // Reset then idle: toggles with en=0 must be ignored.
        do_reset();
        clear_tallies();
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check("idle_count", int'(cnt_w), 0);
            check("idle_event", int'(ev_w), 0);
            check("idle_tc", int'(tc_w), 0);
            check("idle_sat", int'(sat_s), 0);
        end

        // Wrap: 12 back-to-back toggles, count lags each toggle by one edge.
        do_reset();
        tick(1'b0, 1'b0, 1'b1);
        clear_tallies();
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check("wrap_count", int'(cnt_w), (i - 1) % 10);
            check("wrap_tc", int'(tc_w), (i == 11) ? 1 : 0);
            check("wrap_event", int'(ev_w), (i >= 2) ? 1 : 0);
        end
        tick(1'b0, 1'b0, 1'b1);
        check("wrap_final_count", int'(cnt_w), 2);
        check("wrap_last_event", int'(ev_w), 1);
        tick(1'b0, 1'b0, 1'b1);
        check("wrap_quiet_event", int'(ev_w), 0);
        check("wrap_event_total", ev_cnt_w, 12);
        check("wrap_tc_total", tc_cnt_w, 1);

        // Rising-edge-only mode: 8 toggles from 0 give 4 events.
        do_reset();
        tick(1'b0, 1'b0, 1'b1);
        clear_tallies();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 2) check("edge_first", int'(cnt_e), 1);
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("edge_count", int'(cnt_e), 4);
        check("edge_event_total", ev_cnt_e, 4);

        // Saturating variant: 15 toggles, saturate on the 10th event.
        do_reset();
        tick(1'b0, 1'b0, 1'b1);
        clear_tallies();
        for (int i = 1; i <= 15; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check("sat_count", int'(cnt_s), (i - 1 > 9) ? 9 : i - 1);
            check("sat_flag", int'(sat_s), (i >= 11) ? 1 : 0);
            check("sat_tc", int'(tc_s), (i == 11) ? 1 : 0);
        end
        tick(1'b0, 1'b0, 1'b1);
        check("sat_hold_count", int'(cnt_s), 9);
        check("sat_event_total", ev_cnt_s, 10);
        check("sat_tc_total", tc_cnt_s, 1);
        tick(1'b0, 1'b1, 1'b1);
        check("sat_clr_count", int'(cnt_s), 0);
        check("sat_clr_flag", int'(sat_s), 0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("sat_clr_run", int'(cnt_s), 1);

        // Collisions: clr vs counted event, en falling/rising vs event.
        do_reset();
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("col_pre_clr", int'(cnt_w), 5);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("col_clr_count", int'(cnt_w), 0);
        check("col_clr_event", int'(ev_w), 0);
        for (int i = 1; i <= 3; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("col_pre_en", int'(cnt_w), 3);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("col_en_fall_count", int'(cnt_w), 3);
        check("col_en_fall_event", int'(ev_w), 0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("col_en_rise_count", int'(cnt_w), 3);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("col_resume_count", int'(cnt_w), 4);

        // Asynchronous reset between edges at count 7.
        do_reset();
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("arst_pre", int'(cnt_w), 7);
        #2;
        reset_n = 1'b0;
        t_in    = 1'b0;
        en      = 1'b0;
        #1;
        check("arst_count", int'(cnt_w), 0);
        check("arst_sat", int'(sat_s), 0);
        check("arst_event", int'(ev_w), 0);
        check("arst_tc", int'(tc_w), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("arst_after", int'(cnt_w), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
